// File: rtl/dibu_loader_if.sv
// Byte-stream receive port and code-memory write bus between the boot loader
// and its surroundings. The slave side is the loader.
interface dibu_loader_if #(
    parameter int CODE_W = 16,
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              code_w_en;
    logic [ADDR_W-1:0] code_addr;
    logic [CODE_W-1:0] code_in;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, code_w_en, code_addr, code_in
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, code_w_en, code_addr, code_in
    );
endinterface

// File: rtl/dibu_loader.sv
// Boot loader: takes a LEN / data words / XOR-checksum frame from a byte stream,
// writes each word to code memory with a one-cycle pulse, then raises run.
module dibu_loader #(
    parameter int CODE_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_run,
    output logic          o_busy,
    output logic          o_err,
    dibu_loader_if.slave  bus
);
    localparam int BPW  = (CODE_W + 7) / 8;
    localparam int SH_W = BPW * 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CHK, S_RUN, S_ERR
    } state_t;

    state_t            r_state;
    logic              r_run;
    logic              r_busy;
    logic              r_err;
    logic              r_code_w_en;
    logic [ADDR_W-1:0] r_code_addr;
    logic [CODE_W-1:0] r_code_in;
    logic [7:0]        r_len;
    logic [7:0]        r_csum;
    logic [ADDR_W-1:0] r_idx;
    logic [BC_W-1:0]   r_bcnt;
    logic [SH_W-1:0]   r_shift;
    logic [TO_W-1:0]   r_tmo;

    logic              w_xfer;
    logic [SH_W-1:0]   w_shift;
    logic              w_last_byte;
    logic              w_last_word;

    assign bus.rx_ready = r_busy & ~i_start;
    assign w_xfer       = bus.rx_valid & bus.rx_ready;
    // MSB byte arrives first; surplus high bits of the first byte fall off at CODE_W.
    assign w_shift      = (r_shift << 8) | SH_W'(bus.rx_data);
    assign w_last_byte  = (r_bcnt == BC_W'(BPW - 1));
    assign w_last_word  = (r_idx == ADDR_W'(r_len - 8'd1));

    assign o_run         = r_run;
    assign o_busy        = r_busy;
    assign o_err         = r_err;
    assign bus.code_w_en = r_code_w_en;
    assign bus.code_addr = r_code_addr;
    assign bus.code_in   = r_code_in;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_code_w_en <= 1'b0;
            r_code_addr <= '0;
            r_code_in   <= '0;
            r_len       <= '0;
            r_csum      <= '0;
            r_idx       <= '0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_tmo       <= '0;
        end else begin
            r_code_w_en <= 1'b0;
            case (r_state)
                S_LEN, S_DATA, S_CHK: begin
                    if (i_start) begin
                        // Restart: discard partial word, checksum and index.
                        r_state <= S_LEN;
                        r_csum  <= '0;
                        r_idx   <= '0;
                        r_bcnt  <= '0;
                        r_shift <= '0;
                        r_tmo   <= '0;
                    end else if (w_xfer) begin
                        r_tmo <= '0;
                        case (r_state)
                            S_LEN: begin
                                r_len   <= bus.rx_data;
                                r_csum  <= bus.rx_data;
                                r_idx   <= '0;
                                r_bcnt  <= '0;
                                r_state <= (bus.rx_data == 8'd0) ? S_CHK : S_DATA;
                            end
                            S_DATA: begin
                                r_csum  <= r_csum ^ bus.rx_data;
                                r_shift <= w_shift;
                                if (w_last_byte) begin
                                    r_bcnt      <= '0;
                                    r_code_w_en <= 1'b1;
                                    r_code_addr <= r_idx;
                                    r_code_in   <= w_shift[CODE_W-1:0];
                                    r_idx       <= r_idx + 1'b1;
                                    if (w_last_word) r_state <= S_CHK;
                                end else begin
                                    r_bcnt <= r_bcnt + 1'b1;
                                end
                            end
                            default: begin
                                r_busy <= 1'b0;
                                if (bus.rx_data == r_csum) begin
                                    r_run   <= 1'b1;
                                    r_state <= S_RUN;
                                end else begin
                                    r_err   <= 1'b1;
                                    r_state <= S_ERR;
                                end
                            end
                        endcase
                    end else if (r_tmo == TO_W'(TIMEOUT_CYC - 1)) begin
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_IDLE, S_RUN, S_ERR: begin
                    if (i_start) begin
                        r_state <= S_LEN;
                        r_busy  <= 1'b1;
                        r_run   <= 1'b0;
                        r_err   <= 1'b0;
                        r_csum  <= '0;
                        r_idx   <= '0;
                        r_bcnt  <= '0;
                        r_shift <= '0;
                        r_tmo   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_run   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dibu_loader.sv
// Scoreboard bench for dibu_loader: expected code writes are queued as frames are
// sent; a negedge monitor pops and compares on every code_w_en pulse.
module tb_dibu_loader;
    localparam int CODE_W = 16;
    localparam int ADDR_W = 8;
    localparam int TO     = 1023;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [CODE_W-1:0] d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic run, busy, err;

    wr_t        exp_q[$];
    logic [7:0] seq[$];
    int n_cmp   = 0;
    int n_bad   = 0;
    int n_push  = 0;
    int n_pulse = 0;

    dibu_loader_if #(.CODE_W(CODE_W), .ADDR_W(ADDR_W)) bus ();

    dibu_loader #(.CODE_W(CODE_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .o_run   (run),
        .o_busy  (busy),
        .o_err   (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [CODE_W-1:0] d);
        exp_q.push_back({a, d});
        n_push++;
    endtask

    // Entered at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        forever begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_ready wait: byte %0h never accepted", b);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.code_w_en === 1'b1) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL write: unexpected pulse addr %0h data %0h", bus.code_addr, bus.code_in);
            end else begin
                e = exp_q.pop_front();
                chk("write addr", 32'(bus.code_addr), 32'(e.a));
                chk("write data", 32'(bus.code_in), 32'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #12;
        chk("reset run", run, 0);
        chk("reset busy", busy, 0);
        chk("reset err", err, 0);
        chk("reset rx_ready", bus.rx_ready, 0);
        chk("reset code_w_en", bus.code_w_en, 0);
        chk("reset code_in", 32'(bus.code_in), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle rx_ready", bus.rx_ready, 0);

        // Good two-word frame
        pulse_start();
        chk("t1 busy after start", busy, 1);
        push(8'd0, 16'h1234);
        push(8'd1, 16'hABCD);
        seq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_seq();
        chk("t1 run", run, 1);
        chk("t1 err", err, 0);
        chk("t1 busy", busy, 0);
        chk("t1 code_addr hold", 32'(bus.code_addr), 1);
        chk("t1 code_in hold", 32'(bus.code_in), 32'h0000ABCD);

        // Bad checksum, then a good reload
        pulse_start();
        chk("t2 run cleared", run, 0);
        push(8'd0, 16'h1234);
        push(8'd1, 16'hABCD);
        seq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        send_seq();
        chk("t2 err", err, 1);
        chk("t2 run", run, 0);
        chk("t2 busy", busy, 0);
        pulse_start();
        chk("t2 err cleared", err, 0);
        push(8'd0, 16'h1234);
        push(8'd1, 16'hABCD);
        seq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_seq();
        chk("t2 reload run", run, 1);
        chk("t2 reload err", err, 0);

        // Empty frame
        pulse_start();
        seq = '{8'h00};
        send_seq();
        chk("t3 run before chk", run, 0);
        chk("t3 busy before chk", busy, 1);
        seq = '{8'h00};
        send_seq();
        chk("t3 run", run, 1);
        chk("t3 busy", busy, 0);

        // Timeout mid-word
        pulse_start();
        seq = '{8'h02, 8'h12};
        send_seq();
        repeat (TO - 1) @(posedge clk);
        #1;
        chk("t4 err before timeout", err, 0);
        chk("t4 busy before timeout", busy, 1);
        @(posedge clk);
        #1;
        chk("t4 err", err, 1);
        chk("t4 busy", busy, 0);
        chk("t4 rx_ready", bus.rx_ready, 0);
        chk("t4 run", run, 0);

        // Restart in the middle of a frame
        pulse_start();
        push(8'd0, 16'h1234);
        seq = '{8'h02, 8'h12, 8'h34, 8'hAB};
        send_seq();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hCD;
        start = 1'b1;
        @(negedge clk);
        chk("t5 rx_ready during start", bus.rx_ready, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        chk("t5 busy after restart", busy, 1);
        push(8'd0, 16'h1234);
        push(8'd1, 16'hABCD);
        seq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_seq();
        chk("t5 run", run, 1);

        // Asynchronous reset during DATA
        pulse_start();
        push(8'd0, 16'h1234);
        seq = '{8'h02, 8'h12, 8'h34, 8'hAB};
        send_seq();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hCD;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 busy", busy, 0);
        chk("t6 run", run, 0);
        chk("t6 err", err, 0);
        chk("t6 rx_ready", bus.rx_ready, 0);
        chk("t6 code_addr", 32'(bus.code_addr), 0);
        chk("t6 code_in", 32'(bus.code_in), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6 idle rx_ready", bus.rx_ready, 0);
            chk("t6 idle busy", busy, 0);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        pulse_start();
        push(8'd0, 16'h1234);
        push(8'd1, 16'hABCD);
        seq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_seq();
        chk("t6 reload run", run, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard empty", exp_q.size(), 0);
        chk("write pulse count", n_pulse, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
